seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment display.
- Captures a packed hex word plus per-digit decimal points, then scans one digit at a time at a programmable rate.
- Decodes the active digit's nibble to active-low segments and drives active-low anode enables.
- Sits between the datapath/top level and board display pins; it is the clocked, multi-digit successor of the team's single-digit combinational hex decoder.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
- SCAN_DIV, 100000, clk cycles per digit slot; legal when >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit; 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit dark for its slot.
- load  in  1  one-cycle strobe that captures data, dp_in and digit_en into shadow registers.
- an  out  NUM_DIGITS  anode enables, active-low; at most one bit low at any time.
- seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - an = all ones, seg = 7'h7F, dp = 1.
  - Shadow data/dp/en = 0, prescaler = 0, digit index = 0.
- Shadow capture:
  - load = 1 at edge t makes the shadow registers hold the inputs from edge t.
  - Inputs are ignored while load = 0; the display never tears mid-slot because of input changes.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - At terminal count the digit index advances; it wraps from NUM_DIGITS-1 to 0.
  - Index width = max(1, clog2(NUM_DIGITS)).
- Outputs are registered and driven from the shadow registers, the current index and the prescaler value (one-cycle pipeline).
- Guard cycle: while prescaler == 0 (first cycle of every slot), an = all ones, seg = 7F, dp = 1. This is anti-ghosting blanking.
- For the remaining SCAN_DIV-1 cycles of a slot:
  - Enabled digit (shadow en[idx] = 1): an[idx] = 0, others 1; seg = decode(nibble[idx]); dp = ~shadow dp[idx].
  - Disabled digit: an = all ones, seg = 7F, dp = 1. The slot is still consumed, so scan period stays constant.
- Decode table, hex value of seg:
  - 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F
  - 8:00 9:0C A:08 B:60 C:31 D:42 E:30 F:38
- Frame period = NUM_DIGITS*SCAN_DIV cycles, independent of load activity.
- NUM_DIGITS = 1: index stays 0; guard cycle still occurs every SCAN_DIV cycles.
- load coinciding with a slot boundary: the new shadow value is used from the next edge's output computation; no special case.
- rst_n asserted mid-slot: all outputs go to their reset values immediately (asynchronously). Scanning restarts at digit 0 with prescaler = 0 on the first edge after release.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i > 0) is blanked if its shadow nibble and all higher-index shadow nibbles are 0.
  - A blanked digit gets seg = 7F and an[idx] stays high, unless shadow dp[idx] = 1, in which case the anode is driven and only dp is lit.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the shadow registers.
- Undefined: every enabled digit shows its nibble, including leading zeros; no extra logic is synthesised.

Test Plan (NUM_DIGITS = 4, SCAN_DIV = 4):
- Reset check: hold rst_n = 0 for 3 cycles, then release. Outputs stay an = F, seg = 7F, dp = 1 during reset. In the first slot: guard cycle, then an = E with seg = 01 (shadow 0, en = 0 → actually dark: an = F).
- Basic scan: load data = 16'h1A3F, en = F, dp = 0. Per slot after the guard cycle: an = E/seg = 38, an = D/seg = 06, an = B/seg = 08, an = 7/seg = 4F. Repeats every 16 cycles.
- Decimal point and disable: dp_in = 4'b0100, en = 4'b1101. Slot 2 gives an = B, dp = 0. Slot 1 gives an = F, seg = 7F, and the slot lasts 4 cycles.
- Guard cycle: across the boundary between slot 0 and slot 1, exactly one cycle has an = F between an = E and an = D. an never has two bits low.
- Async reset: assert rst_n mid-slot 2 with no clock edge. an = F and seg = 7F immediately. After release, scanning resumes at slot 0.
- With SEG7_LEADING_ZERO_BLANK_EN: load data = 16'h0050, dp = 4'b1000. Digit 3 shows only dp (an = 7, seg = 7F, dp = 0). Digit 2 is dark (an = F). Digits 1 and 0 show 24 and 01.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment
// display. A one-cycle load strobe captures the hex word, decimal points and
// digit enables into shadow registers. A prescaler then steps through the
// digits, giving each one SCAN_DIV clock cycles. The first cycle of every
// slot is blanked so that the previous digit does not ghost onto the next.
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, leading zero digits (index > 0)
//   are blanked. A blanked digit whose decimal point is requested still
//   drives its anode and lights only the dp.
//
// Parameters:
//   NUM_DIGITS  number of scanned digits (1..16)
//   SCAN_DIV    clk cycles per digit slot (>= 2)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   data      in   4*NUM_DIGITS hex nibbles, digit i = data[4i+3:4i]
//   dp_in     in   NUM_DIGITS decimal point requests, 1 = lit
//   digit_en  in   NUM_DIGITS per-digit enables, 0 = digit dark
//   load      in   capture strobe for data/dp_in/digit_en
//   an        out  NUM_DIGITS active-low anode enables (at most one low)
//   seg       out  7 active-low segments {a,b,c,d,e,f,g}
//   dp        out  active-low decimal point
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW    = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(SCAN_DIV - 1);

  // Shadow registers
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;

  // Scan state
  logic [PW-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0] idx_q,   idx_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q,  an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q_o, dp_d;

  // Active-digit selection
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_en;
  logic [NUM_DIGITS-1:0] sel_an;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h0C;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  // Prescaler and digit index: the index moves only on prescaler terminal
  // count, so the frame period never depends on load activity.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // zero_from[i] = nibble i and every higher nibble are zero
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_acc;
  int unsigned           zi;
  logic                  cur_blank;

  always_comb begin
    zero_acc  = 1'b1;
    zero_from = '0;
    zi        = 0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zi            = NUM_DIGITS - 1 - k;
      zero_acc      = zero_acc & (data_q[4*zi +: 4] == 4'h0);
      zero_from[zi] = zero_acc;
    end
  end
`endif

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    sel_an  = '1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    cur_blank = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = data_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_en    = en_q[i];
        sel_an[i] = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        cur_blank = (i != 0) && zero_from[i];
`endif
      end
    end
  end

  // Output computation; prescaler == 0 is the anti-ghosting guard cycle.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((presc_q != '0) && cur_en) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (cur_blank) begin
        // Blanked digit still shows a requested decimal point.
        if (cur_dp) begin
          an_d = sel_an;
          dp_d = 1'b0;
        end
      end else begin
        an_d  = sel_an;
        seg_d = hex_to_seg(cur_nib);
        dp_d  = ~cur_dp;
      end
`else
      an_d  = sel_an;
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~cur_dp;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dp_q    <= '0;
      en_q    <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q_o  <= 1'b1;
    end else begin
      if (load) begin
        data_q <= data;
        dp_q   <= dp_in;
        en_q   <= digit_en;
      end
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q_o  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q_o;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   data = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    digit_en = '0;
  logic          load = 1'b0;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [15:0]   m_data = '0;
  logic [3:0]    m_dp   = '0;
  logic [3:0]    m_en   = '0;
  int unsigned   p_cnt  = 0;
  logic [3:0]    e_an;
  logic [6:0]    e_seg;
  logic          e_dp;

  logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (p=%0d t=%0t)", tag, got, exp, p_cnt, $time);
    end
  endtask

  // Expected outputs for the registered cycle reflecting scan position p.
  task automatic model_expect(input int unsigned p);
    int unsigned slot;
    int unsigned ph;
    logic [3:0]  nib;
    logic        blanked;
    slot  = (p / SD) % ND;
    ph    = p % SD;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (ph != 0 && m_en[slot]) begin
      nib     = 4'((m_data >> (4 * slot)) & 16'hF);
      blanked = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (slot > 0 && (m_data >> (4 * slot)) == 16'h0) blanked = 1'b1;
`endif
      if (!blanked) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = seg_tbl[nib];
        e_dp  = ~m_dp[slot];
      end else if (m_dp[slot]) begin
        e_an = ~(4'b0001 << slot);
        e_dp = 1'b0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
    check("an_onehot", 16'($countones(~an) <= 1), 16'd1);
  endtask

  // Called at a negedge: drive, take one posedge, check at the next negedge.
  task automatic run_cycle(input logic ld, input logic [15:0] d,
                           input logic [3:0] dpv, input logic [3:0] env);
    load     = ld;
    data     = d;
    dp_in    = dpv;
    digit_en = env;
    @(posedge clk);
    model_expect(p_cnt);
    p_cnt++;
    if (ld) begin
      m_data = d;
      m_dp   = dpv;
      m_en   = env;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      run_cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic reset_model();
    m_data = '0;
    m_dp   = '0;
    m_en   = '0;
    p_cnt  = 0;
  endtask

  initial begin
    // Reset held for three cycles
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_an", 16'(an), 16'hF);
      check("rst_seg", 16'(seg), 16'h7F);
      check("rst_dp", 16'(dp), 16'h1);
    end
    rst_n = 1'b1;
    reset_model();

    // Shadow is zero with all digits disabled: dark
    idle_cycles(8);

    // Basic scan
    run_cycle(1'b1, 16'h1A3F, 4'h0, 4'hF);
    idle_cycles(40);

    // Decimal point and disabled digit
    run_cycle(1'b1, 16'h1A3F, 4'b0100, 4'b1101);
    idle_cycles(36);

    // Leading-zero pattern (model follows the build macro)
    run_cycle(1'b1, 16'h0050, 4'b1000, 4'hF);
    idle_cycles(36);

    // Load landing on a slot boundary (next position is a guard cycle)
    for (int k = 0; k < 8 && (p_cnt % SD) != SD - 1; k++) idle_cycles(1);
    run_cycle(1'b1, 16'hB7C2, 4'b0011, 4'hF);
    idle_cycles(20);

    // Async reset mid-slot 2, no clock edge before the check
    for (int k = 0; k < 40 && !(((p_cnt / SD) % ND) == 2 && (p_cnt % SD) == 2); k++)
      idle_cycles(1);
    check("pre_async_slot", 16'((p_cnt / SD) % ND), 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", 16'(an), 16'hF);
    check("async_seg", 16'(seg), 16'h7F);
    check("async_dp", 16'(dp), 16'h1);
    @(negedge clk);
    @(negedge clk);
    check("async_hold_an", 16'(an), 16'hF);
    rst_n = 1'b1;
    reset_model();
    run_cycle(1'b1, 16'h9E46, 4'b1010, 4'hF);
    idle_cycles(20);

    // Randomized traffic with occasional loads
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0)
        run_cycle(1'b1, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                  4'($urandom), 4'($urandom));
      else
        idle_cycles(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
